muscle_bank: RTL and testbench

MUSCLE_BANK -- requirements
Module: muscle_bank

---
 rtl/muscle_bank.sv | 155 +++++++++++++++
 tb/tb_muscle_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muscle_bank.sv
`default_nettype none
// ============================================================================
//  Module      : muscle_bank
//  Description : Time-multiplexed muscle model bank; one channel per cycle,
//                double-buffered EMG/torque outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module muscle_bank #(
    parameter int NCH      = 4,
    parameter int NN       = 8,
    parameter int AS_SHIFT = 7,
    parameter int TQ_SHIFT = 8,
    parameter int HP_SHIFT = 4,
    parameter int LP_SHIFT = 2
) (
    input  logic                    nClock,
    input  logic                    neuronReset,
    input  logic                    start,
    input  logic [NCH*(NN+1)-1:0]   spikes_flat,
    output logic                    busy,
    output logic                    done,
    output logic [NCH*18-1:0]       emg_flat,
    output logic [NCH*18-1:0]       torque_flat,
    output logic [NCH-1:0]          overflow,
    output logic                    start_miss
);

    localparam int              c_IW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [c_IW-1:0] c_LAST   = c_IW'(NCH - 1);
    localparam logic [1:0]      c_IDLE   = 2'd0;
    localparam logic [1:0]      c_RUN    = 2'd1;
    localparam logic [1:0]      c_COMMIT = 2'd2;

    logic [1:0]               r_state;
    logic [c_IW-1:0]          r_idx;
    logic [NCH*(NN+1)-1:0]    r_spk;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_start_miss;
    logic [NCH-1:0]           r_overflow;
    logic [NCH*18-1:0]        r_emg;
    logic [NCH*18-1:0]        r_torque;
    logic signed [35:0]       r_as [NCH];
    logic signed [35:0]       r_hp [NCH];
    logic signed [35:0]       r_lp [NCH];
    logic signed [35:0]       r_tq [NCH];

    function automatic logic signed [37:0] sx(input logic signed [35:0] v);
        return {{2{v[35]}}, v};
    endfunction

    // Top three bits disagree when the 38-bit sum left the 36-bit range
    function automatic logic ovf(input logic signed [37:0] s);
        return (s[37:35] != 3'b000) && (s[37:35] != 3'b111);
    endfunction

    function automatic logic signed [35:0] sat(input logic signed [37:0] s);
        if (ovf(s))
            return s[37] ? {1'b1, 35'd0} : {1'b0, {35{1'b1}}};
        return s[35:0];
    endfunction

    logic [NN:0]              w_spk;
    logic signed [35:0]       w_stim;
    logic signed [35:0]       w_as;
    logic signed [35:0]       w_hp;
    logic signed [35:0]       w_lp;
    logic signed [35:0]       w_tq;
    logic signed [37:0]       w_as_sum;
    logic signed [37:0]       w_hp_sum;
    logic signed [37:0]       w_lp_sum;
    logic signed [37:0]       w_tq_sum;
    logic                     w_ovf;
    logic [NCH*18-1:0]        w_emg_all;
    logic [NCH*18-1:0]        w_torque_all;

    assign w_spk    = r_spk[r_idx*(NN+1) +: NN+1];
    assign w_stim   = {{(28-NN){1'b0}}, w_spk, 7'd0};
    assign w_as     = r_as[r_idx];
    assign w_hp     = r_hp[r_idx];
    assign w_lp     = r_lp[r_idx];
    assign w_tq     = r_tq[r_idx];
    assign w_as_sum = sx(w_as) - sx(w_as >>> AS_SHIFT) + sx(w_stim <<< 11);
    assign w_hp_sum = sx(w_hp) + sx(w_stim >>> HP_SHIFT) - sx(w_hp >>> HP_SHIFT);
    assign w_lp_sum = sx(w_lp) - sx(w_lp >>> LP_SHIFT) + sx(w_stim >>> LP_SHIFT);
    assign w_tq_sum = sx(w_tq) - sx(w_tq >>> TQ_SHIFT) + sx(w_as >>> 5) + sx(w_as >>> 6);
    assign w_ovf    = ovf(w_as_sum) | ovf(w_hp_sum) | ovf(w_lp_sum) | ovf(w_tq_sum);

    for (genvar k = 0; k < NCH; k++) begin : g_out
        assign w_emg_all[k*18 +: 18]    = r_lp[k][17:0] - r_hp[k][17:0];
        assign w_torque_all[k*18 +: 18] = r_tq[k][35] ? 18'd0 : r_tq[k][35:18];
    end

    always_ff @(posedge nClock) begin
        if (neuronReset) begin
            r_state      <= c_IDLE;
            r_idx        <= '0;
            r_spk        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_start_miss <= 1'b0;
            r_overflow   <= '0;
            r_emg        <= '0;
            r_torque     <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_as[k] <= '0;
                r_hp[k] <= '0;
                r_lp[k] <= '0;
                r_tq[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_spk   <= spikes_flat;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_as[r_idx]       <= sat(w_as_sum);
                    r_hp[r_idx]       <= sat(w_hp_sum);
                    r_lp[r_idx]       <= sat(w_lp_sum);
                    r_tq[r_idx]       <= sat(w_tq_sum);
                    r_overflow[r_idx] <= r_overflow[r_idx] | w_ovf;
                    if (r_idx == c_LAST)
                        r_state <= c_COMMIT;
                    else
                        r_idx <= r_idx + 1'b1;
                end
                c_COMMIT: begin
                    r_emg    <= w_emg_all;
                    r_torque <= w_torque_all;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
            if (start && (r_state != c_IDLE))
                r_start_miss <= 1'b1;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign emg_flat    = r_emg;
    assign torque_flat = r_torque;
    assign overflow    = r_overflow;
    assign start_miss  = r_start_miss;

endmodule
`default_nettype wire

// File: tb/tb_muscle_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muscle_bank
//  Description : Scoreboard bench for muscle_bank with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muscle_bank;

    localparam int NCH = 4;
    localparam int NN  = 8;
    localparam int W   = NCH*(NN+1);
    localparam int O   = NCH*18;
    localparam longint MAX36 = 64'sd34359738367;
    localparam longint MIN36 = -64'sd34359738368;

    logic           nClock = 1'b0;
    logic           neuronReset;
    logic           start;
    logic [W-1:0]   spikes_flat;
    logic           busy;
    logic           done;
    logic [O-1:0]   emg_flat;
    logic [O-1:0]   torque_flat;
    logic [NCH-1:0] overflow;
    logic           start_miss;

    muscle_bank dut (
        .nClock      (nClock),
        .neuronReset (neuronReset),
        .start       (start),
        .spikes_flat (spikes_flat),
        .busy        (busy),
        .done        (done),
        .emg_flat    (emg_flat),
        .torque_flat (torque_flat),
        .overflow    (overflow),
        .start_miss  (start_miss)
    );

    always #5 nClock = ~nClock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [O-1:0]   emg;
        logic [O-1:0]   tq;
        logic [NCH-1:0] ovf;
    } exp_t;
    exp_t sbq[$];

    longint         m_as [NCH];
    longint         m_hp [NCH];
    longint         m_lp [NCH];
    longint         m_tq [NCH];
    logic [NCH-1:0] m_ovf;

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_as[k] = 0; m_hp[k] = 0; m_lp[k] = 0; m_tq[k] = 0;
        end
        m_ovf = '0;
    endtask

    task automatic clamp(inout longint v, input int k);
        if (v > MAX36) begin v = MAX36; m_ovf[k] = 1'b1; end
        else if (v < MIN36) begin v = MIN36; m_ovf[k] = 1'b1; end
    endtask

    // Advance the model by one run and queue the outputs the DUT must show
    task automatic model_run(input logic [W-1:0] spk);
        exp_t   e;
        longint stim, a, h, l, t;
        logic [17:0] ev;
        for (int k = 0; k < NCH; k++) begin
            stim = longint'(spk[k*(NN+1) +: NN+1]) * 128;
            a = m_as[k] - (m_as[k] >>> 7) + stim * 2048;
            h = m_hp[k] + (stim >>> 4) - (m_hp[k] >>> 4);
            l = m_lp[k] - (m_lp[k] >>> 2) + (stim >>> 2);
            t = m_tq[k] - (m_tq[k] >>> 8) + (m_as[k] >>> 5) + (m_as[k] >>> 6);
            clamp(a, k); clamp(h, k); clamp(l, k); clamp(t, k);
            m_as[k] = a; m_hp[k] = h; m_lp[k] = l; m_tq[k] = t;
        end
        for (int k = 0; k < NCH; k++) begin
            ev = 18'(m_lp[k] - m_hp[k]);
            e.emg[k*18 +: 18] = ev;
            e.tq[k*18 +: 18]  = (m_tq[k] < 0) ? 18'd0 : 18'(m_tq[k] >>> 18);
        end
        e.ovf = m_ovf;
        sbq.push_back(e);
    endtask

    always @(negedge nClock) begin
        if (!neuronReset && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_emg", emg_flat, e.emg);
                chk("sb_torque", torque_flat, e.tq);
                chk("sb_overflow", overflow, e.ovf);
            end
        end
    end

    task automatic do_reset();
        @(posedge nClock); #1;
        neuronReset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge nClock);
        #1 neuronReset = 1'b0;
        model_reset();
    endtask

    // Edge 0 samples start; cycle c is observed 1 time unit after edge c
    task automatic run_cmd(input logic [W-1:0] spk, input int extra_at, input int rst_at,
                           output int dcyc, output int dcnt, output logic busy1,
                           output logic busy_end);
        dcyc = 0;
        dcnt = 0;
        busy_end = 1'b1;
        if (rst_at == 0) model_run(spk);
        spikes_flat = spk;
        start = 1'b1;
        @(posedge nClock); #1;
        start = 1'b0;
        busy1 = busy;
        for (int c = 1; c <= NCH + 4; c++) begin
            start       = (c == extra_at);
            neuronReset = (c == rst_at);
            @(posedge nClock); #1;
            if (done) begin
                dcnt++;
                if (dcyc == 0) dcyc = c;
            end
            if (c == NCH + 2) busy_end = busy;
        end
        start = 1'b0;
        neuronReset = 1'b0;
        if (rst_at != 0) model_reset();
    endtask

    int   dcyc, dcnt;
    logic b1, be;
    logic [W-1:0] ch0_one, ch2_max;

    initial begin
        neuronReset = 1'b1;
        start       = 1'b0;
        spikes_flat = '0;
        model_reset();
        ch0_one = '0;
        ch0_one[0 +: NN+1] = 9'd1;
        ch2_max = '0;
        ch2_max[2*(NN+1) +: NN+1] = 9'd511;

        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge nClock); #1;
            chk("idle_done", done, 0);
        end
        chk("rst_emg", emg_flat, 0);
        chk("rst_torque", torque_flat, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_start_miss", start_miss, 0);
        chk("rst_busy", busy, 0);

        run_cmd(ch0_one, 0, 0, dcyc, dcnt, b1, be);
        chk("r1_done_cycle", dcyc, 5);
        chk("r1_done_count", dcnt, 1);
        chk("r1_busy_c1", b1, 1);
        chk("r1_busy_end", be, 0);
        chk("r1_emg", emg_flat, 72'd24);
        chk("r1_torque", torque_flat, 0);
        chk("r1_as0", dut.r_as[0], 128'd262144);

        run_cmd('0, 0, 0, dcyc, dcnt, b1, be);
        chk("r2_emg0", emg_flat[17:0], 18'd16);
        chk("r2_torque", torque_flat, 0);
        chk("r2_as0", dut.r_as[0], 128'd260096);
        chk("r2_tq0", dut.r_tq[0], 128'd12288);

        do_reset();
        run_cmd(ch0_one, 2, 0, dcyc, dcnt, b1, be);
        chk("miss_flag", start_miss, 1);
        chk("miss_done_count", dcnt, 1);
        chk("miss_done_cycle", dcyc, 5);
        chk("miss_emg", emg_flat, 72'd24);

        do_reset();
        run_cmd(ch0_one, 0, 3, dcyc, dcnt, b1, be);
        chk("abort_done_count", dcnt, 0);
        chk("abort_emg", emg_flat, 0);
        chk("abort_torque", torque_flat, 0);
        chk("abort_busy", busy, 0);
        run_cmd(ch0_one, 0, 0, dcyc, dcnt, b1, be);
        chk("post_abort_cycle", dcyc, 5);
        chk("post_abort_emg", emg_flat, 72'd24);
        chk("post_abort_as0", dut.r_as[0], 128'd262144);

        do_reset();
        for (int r = 0; r < 2000; r++) begin
            run_cmd(ch2_max, 0, 0, dcyc, dcnt, b1, be);
            if (dcnt != 1) chk("sat_done_count", dcnt, 1);
            if (torque_flat[2*18 + 17] !== 1'b0) chk("sat_torque_sign", torque_flat[2*18 + 17], 0);
        end
        chk("sat_torque_nonneg", torque_flat[2*18 + 17], 0);
        chk("sat_overflow", overflow, 4'b0100);
        chk("sat_others_emg", {emg_flat[71:54], emg_flat[35:0]}, 0);
        chk("sat_others_torque", {torque_flat[71:54], torque_flat[35:0]}, 0);
        chk("sat_torque_ch2", torque_flat[2*18 +: 18], 18'd131071);

        repeat (3) @(posedge nClock);
        #1 chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
